// File: rtl/usb_reg_arbiter_if.sv
// rtl/usb_reg_arbiter_if.sv - requester and downstream register bus bundle for usb_reg_arbiter
interface usb_reg_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 9,
    parameter int DW      = 32
);
    logic [NUM_REQ-1:0]        req_cs;
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ*AW-1:0]     req_addr;
    logic [NUM_REQ*DW-1:0]     req_wdata;
    logic [NUM_REQ*DW/8-1:0]   req_be;
    logic [DW-1:0]             req_rdata;
    logic [NUM_REQ-1:0]        req_ack;
    logic [NUM_REQ-1:0]        req_err;

    logic                      reg_cs;
    logic                      reg_wr;
    logic [AW-1:0]             reg_addr;
    logic [DW-1:0]             reg_wdata;
    logic [DW/8-1:0]           reg_be;
    logic [DW-1:0]             reg_rdata;
    logic                      reg_ack;

    modport master (
        input  req_cs, req_wr, req_addr, req_wdata, req_be, reg_rdata, reg_ack,
        output req_rdata, req_ack, req_err, reg_cs, reg_wr, reg_addr, reg_wdata, reg_be
    );

    modport slave (
        output req_cs, req_wr, req_addr, req_wdata, req_be, reg_rdata, reg_ack,
        input  req_rdata, req_ack, req_err, reg_cs, reg_wr, reg_addr, reg_wdata, reg_be
    );
endinterface

// File: rtl/usb_reg_arbiter.sv
// rtl/usb_reg_arbiter.sv - round-robin arbiter with timeout for the shared USB-host register bus
module usb_reg_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 9,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              app_clk,
    input  logic              app_rst,
    usb_reg_arbiter_if.master bus,
    output logic              arb_busy,
    output logic [1:0]        arb_grant
);

    localparam int BW = DW / 8;
    localparam int PW = (NUM_REQ > 2) ? 2 : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [PW-1:0] P_LAST = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state, state_n;
    logic [PW-1:0]       ptr, ptr_n;
    logic [TW-1:0]       timer, timer_n;
    logic                abort_q, abort_n;

    logic                reg_cs_n, reg_wr_n;
    logic [AW-1:0]       reg_addr_n;
    logic [DW-1:0]       reg_wdata_n, req_rdata_n;
    logic [BW-1:0]       reg_be_n;
    logic [NUM_REQ-1:0]  req_ack_n, req_err_n;
    logic                arb_busy_n;
    logic [1:0]          arb_grant_n;

    logic                found;
    logic [PW-1:0]       sel;
    logic                sel_wr;
    logic [AW-1:0]       sel_addr;
    logic [DW-1:0]       sel_wdata;
    logic [BW-1:0]       sel_be;
    logic                live;

    // Search starts one past the last winner and wraps, so the last winner has lowest priority.
    always_comb begin
        logic [PW-1:0] cand;
        found = 1'b0;
        sel   = ptr;
        cand  = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == P_LAST) ? '0 : cand + PW'(1);
            if (!found && bus.req_cs[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == PW'(i)) begin
                sel_wr    = bus.req_wr[i];
                sel_addr  = bus.req_addr[i*AW +: AW];
                sel_wdata = bus.req_wdata[i*DW +: DW];
                sel_be    = bus.req_be[i*BW +: BW];
            end
        end
    end

    // The access still completes downstream if its requester withdrew; only the notification is dropped.
    assign live = !abort_q && bus.req_cs[ptr];

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        timer_n     = timer;
        abort_n     = abort_q;
        reg_cs_n    = bus.reg_cs;
        reg_wr_n    = bus.reg_wr;
        reg_addr_n  = bus.reg_addr;
        reg_wdata_n = bus.reg_wdata;
        reg_be_n    = bus.reg_be;
        req_rdata_n = bus.req_rdata;
        req_ack_n   = '0;
        req_err_n   = '0;
        arb_grant_n = arb_grant;

        case (state)
            IDLE: begin
                if (found) begin
                    reg_cs_n    = 1'b1;
                    reg_wr_n    = sel_wr;
                    reg_addr_n  = sel_addr;
                    reg_wdata_n = sel_wdata;
                    reg_be_n    = sel_be;
                    arb_grant_n = 2'(sel);
                    ptr_n       = sel;
                    timer_n     = '0;
                    abort_n     = 1'b0;
                    state_n     = BUSY;
                end
            end
            BUSY: begin
                timer_n = timer + TW'(1);
                if (!bus.req_cs[ptr]) begin
                    abort_n = 1'b1;
                end
                if (bus.reg_ack) begin
                    reg_cs_n    = 1'b0;
                    req_rdata_n = bus.reg_rdata;
                    req_ack_n   = live ? (NUM_REQ'(1) << ptr) : '0;
                    state_n     = DONE;
                end else if (TIMEOUT != 0 && timer == T_LAST) begin
                    reg_cs_n    = 1'b0;
                    req_rdata_n = '1;
                    req_ack_n   = live ? (NUM_REQ'(1) << ptr) : '0;
                    req_err_n   = live ? (NUM_REQ'(1) << ptr) : '0;
                    state_n     = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n  = IDLE;
                reg_cs_n = 1'b0;
            end
        endcase

        arb_busy_n = (state_n != IDLE);
    end

    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            state         <= IDLE;
            ptr           <= P_LAST;
            timer         <= '0;
            abort_q       <= 1'b0;
            bus.reg_cs    <= 1'b0;
            bus.reg_wr    <= 1'b0;
            bus.reg_addr  <= '0;
            bus.reg_wdata <= '0;
            bus.reg_be    <= '0;
            bus.req_rdata <= '0;
            bus.req_ack   <= '0;
            bus.req_err   <= '0;
            arb_busy      <= 1'b0;
            arb_grant     <= '0;
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            timer         <= timer_n;
            abort_q       <= abort_n;
            bus.reg_cs    <= reg_cs_n;
            bus.reg_wr    <= reg_wr_n;
            bus.reg_addr  <= reg_addr_n;
            bus.reg_wdata <= reg_wdata_n;
            bus.reg_be    <= reg_be_n;
            bus.req_rdata <= req_rdata_n;
            bus.req_ack   <= req_ack_n;
            bus.req_err   <= req_err_n;
            arb_busy      <= arb_busy_n;
            arb_grant     <= arb_grant_n;
        end
    end

endmodule
